// File: rtl/candidate_best_selector.sv
`default_nettype none
// ============================================================================
// Module      : candidate_best_selector
// Description : Captures a centre candidate and its eight neighbours, scans
//               them serially (one per cycle) and reports the lowest-cost
//               motion vector with its index. Neighbour costs receive an
//               optional saturating bias; ties keep the lower index.
// Revision    : 1.0 - initial release
// ============================================================================
module candidate_best_selector #(
  parameter int DATA_WIDTH = 16,
  parameter int ZERO_BIAS  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    candidate_ready_flag,
  input  logic [3*DATA_WIDTH-1:0] candidate_center,
  input  logic [3*DATA_WIDTH-1:0] candidate_top_left,
  input  logic [3*DATA_WIDTH-1:0] candidate_top_middle,
  input  logic [3*DATA_WIDTH-1:0] candidate_top_right,
  input  logic [3*DATA_WIDTH-1:0] candidate_middle_left,
  input  logic [3*DATA_WIDTH-1:0] candidate_middle_right,
  input  logic [3*DATA_WIDTH-1:0] candidate_bottom_left,
  input  logic [3*DATA_WIDTH-1:0] candidate_bottom_middle,
  input  logic [3*DATA_WIDTH-1:0] candidate_bottom_right,
  input  logic [7:0]              candidate_valid_mask,
  output logic                    busy,
  output logic                    best_valid,
  output logic [DATA_WIDTH-1:0]   best_mv_x,
  output logic [DATA_WIDTH-1:0]   best_mv_y,
  output logic [DATA_WIDTH-1:0]   best_cost,
  output logic [3:0]              best_index
);

  localparam int                  c_cw       = 3 * DATA_WIDTH;
  localparam int                  c_num      = 9;
  localparam logic [DATA_WIDTH:0] c_bias     = (DATA_WIDTH+1)'(ZERO_BIAS);
  localparam logic [DATA_WIDTH:0] c_cost_max = {1'b0, {DATA_WIDTH{1'b1}}};
  localparam logic [3:0]          c_last_idx = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [c_cw-1:0]         cand_q [c_num];
  logic [c_cw-1:0]         w_cand_in [c_num];
  logic [7:0]              mask_q;
  logic                    w_load;

  logic [3:0]              idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wb_mv_x_q, wb_mv_x_d;
  logic [DATA_WIDTH-1:0]   wb_mv_y_q, wb_mv_y_d;
  logic [DATA_WIDTH-1:0]   wb_cost_q, wb_cost_d;
  logic [3:0]              wb_idx_q, wb_idx_d;

  logic                    best_valid_q, best_valid_d;
  logic [DATA_WIDTH-1:0]   best_mv_x_q, best_mv_x_d;
  logic [DATA_WIDTH-1:0]   best_mv_y_q, best_mv_y_d;
  logic [DATA_WIDTH-1:0]   best_cost_q, best_cost_d;
  logic [3:0]              best_index_q, best_index_d;

  logic [c_cw-1:0]         w_cur;
  logic                    w_use;
  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH-1:0]   w_eff;
  logic                    w_better;

  // Gather the nine candidate ports into an array ordered by index.
  always_comb begin
    w_cand_in[0] = candidate_center;
    w_cand_in[1] = candidate_top_left;
    w_cand_in[2] = candidate_top_middle;
    w_cand_in[3] = candidate_top_right;
    w_cand_in[4] = candidate_middle_left;
    w_cand_in[5] = candidate_middle_right;
    w_cand_in[6] = candidate_bottom_left;
    w_cand_in[7] = candidate_bottom_middle;
    w_cand_in[8] = candidate_bottom_right;
  end

  // Select the neighbour under evaluation and its usable bit (index 0 is never scanned).
  always_comb begin
    w_cur = '0;
    w_use = 1'b0;
    for (int i = 1; i < c_num; i++) begin
      if (idx_q == 4'(i)) begin
        w_cur = cand_q[i];
        w_use = mask_q[i-1];
      end
    end
  end

  // Biased neighbour cost, clamped to the largest representable cost.
  always_comb begin
    w_sum    = {1'b0, w_cur[DATA_WIDTH-1:0]} + c_bias;
    w_eff    = (w_sum > c_cost_max) ? c_cost_max[DATA_WIDTH-1:0] : w_sum[DATA_WIDTH-1:0];
    w_better = w_use && (w_eff < wb_cost_q);
  end

  // Capture the candidate set and mask when a new set is accepted; no reset needed for data.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int i = 0; i < c_num; i++) begin
        cand_q[i] <= w_cand_in[i];
      end
      mask_q <= candidate_valid_mask;
    end
  end

  // State, scan index, working best and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      wb_mv_x_q    <= '0;
      wb_mv_y_q    <= '0;
      wb_cost_q    <= '0;
      wb_idx_q     <= '0;
      best_valid_q <= 1'b0;
      best_mv_x_q  <= '0;
      best_mv_y_q  <= '0;
      best_cost_q  <= '0;
      best_index_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wb_mv_x_q    <= wb_mv_x_d;
      wb_mv_y_q    <= wb_mv_y_d;
      wb_cost_q    <= wb_cost_d;
      wb_idx_q     <= wb_idx_d;
      best_valid_q <= best_valid_d;
      best_mv_x_q  <= best_mv_x_d;
      best_mv_y_q  <= best_mv_y_d;
      best_cost_q  <= best_cost_d;
      best_index_q <= best_index_d;
    end
  end

  // Next-state logic: accept in IDLE, one neighbour per SCAN cycle, publish in DONE.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wb_mv_x_d    = wb_mv_x_q;
    wb_mv_y_d    = wb_mv_y_q;
    wb_cost_d    = wb_cost_q;
    wb_idx_d     = wb_idx_q;
    w_load       = 1'b0;
    best_valid_d = 1'b0;
    best_mv_x_d  = best_mv_x_q;
    best_mv_y_d  = best_mv_y_q;
    best_cost_d  = best_cost_q;
    best_index_d = best_index_q;

    case (state_q)
      ST_IDLE: begin
        // Acceptance depends on the state alone, so a start in the cycle of the
        // result pulse (busy still high) is taken at the following edge.
        if (candidate_ready_flag) begin
          w_load    = 1'b1;
          state_d   = ST_SCAN;
          idx_d     = 4'd1;
          wb_mv_x_d = candidate_center[3*DATA_WIDTH-1:2*DATA_WIDTH];
          wb_mv_y_d = candidate_center[2*DATA_WIDTH-1:DATA_WIDTH];
          wb_cost_d = candidate_center[DATA_WIDTH-1:0];
          wb_idx_d  = 4'd0;
        end
      end
      ST_SCAN: begin
        if (w_better) begin
          wb_mv_x_d = w_cur[3*DATA_WIDTH-1:2*DATA_WIDTH];
          wb_mv_y_d = w_cur[2*DATA_WIDTH-1:DATA_WIDTH];
          wb_cost_d = w_eff;
          wb_idx_d  = idx_q;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == c_last_idx) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        best_valid_d = 1'b1;
        best_mv_x_d  = wb_mv_x_q;
        best_mv_y_d  = wb_mv_y_q;
        best_cost_d  = wb_cost_q;
        best_index_d = wb_idx_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Busy covers the scan and the cycle in which the result is presented.
  always_comb begin
    busy = (state_q != ST_IDLE) || best_valid_q;
  end

  assign best_valid = best_valid_q;
  assign best_mv_x  = best_mv_x_q;
  assign best_mv_y  = best_mv_y_q;
  assign best_cost  = best_cost_q;
  assign best_index = best_index_q;

endmodule
`default_nettype wire

// File: tb/tb_candidate_best_selector.sv
`default_nettype none
// ============================================================================
// Module      : tb_candidate_best_selector
// Description : Directed bench for candidate_best_selector; an unbiased and a
//               biased (ZERO_BIAS=10) instance share stimulus, and expected
//               results are queued at start and checked on each result pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_candidate_best_selector;

  typedef struct {
    logic [15:0] mvx;
    logic [15:0] mvy;
    logic [15:0] cost;
    logic [3:0]  idx;
    int          vcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [47:0] cand [9];
  logic [7:0]  mask;

  logic        busy0, valid0, busy1, valid1;
  logic [15:0] mvx0, mvy0, cost0, mvx1, mvy1, cost1;
  logic [3:0]  idx0, idx1;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   pushed = 0;
  int   pulses0 = 0;
  int   pulses1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  candidate_best_selector #(.DATA_WIDTH(16), .ZERO_BIAS(0)) dut0 (
    .clk(clk), .rst(rst), .candidate_ready_flag(start),
    .candidate_center(cand[0]), .candidate_top_left(cand[1]),
    .candidate_top_middle(cand[2]), .candidate_top_right(cand[3]),
    .candidate_middle_left(cand[4]), .candidate_middle_right(cand[5]),
    .candidate_bottom_left(cand[6]), .candidate_bottom_middle(cand[7]),
    .candidate_bottom_right(cand[8]), .candidate_valid_mask(mask),
    .busy(busy0), .best_valid(valid0), .best_mv_x(mvx0), .best_mv_y(mvy0),
    .best_cost(cost0), .best_index(idx0)
  );

  candidate_best_selector #(.DATA_WIDTH(16), .ZERO_BIAS(10)) dut1 (
    .clk(clk), .rst(rst), .candidate_ready_flag(start),
    .candidate_center(cand[0]), .candidate_top_left(cand[1]),
    .candidate_top_middle(cand[2]), .candidate_top_right(cand[3]),
    .candidate_middle_left(cand[4]), .candidate_middle_right(cand[5]),
    .candidate_bottom_left(cand[6]), .candidate_bottom_middle(cand[7]),
    .candidate_bottom_right(cand[8]), .candidate_valid_mask(mask),
    .busy(busy1), .best_valid(valid1), .best_mv_x(mvx1), .best_mv_y(mvy1),
    .best_cost(cost1), .best_index(idx1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Candidate i gets a distinctive motion vector so the reported mv identifies the winner.
  task automatic set_cost(input int i, input logic [15:0] c);
    cand[i] = {16'(i * 7 + 1), 16'(16'hA000 + i), c};
  endtask

  task automatic set_all(input logic [15:0] c);
    for (int i = 0; i < 9; i++) set_cost(i, c);
  endtask

  task automatic push_exp(input int i0, input logic [15:0] c0, input int i1,
                          input logic [15:0] c1, input int vcyc);
    exp_t e;
    e.mvx = cand[i0][47:32]; e.mvy = cand[i0][31:16]; e.cost = c0; e.idx = 4'(i0); e.vcyc = vcyc;
    q0.push_back(e);
    e.mvx = cand[i1][47:32]; e.mvy = cand[i1][31:16]; e.cost = c1; e.idx = 4'(i1); e.vcyc = vcyc;
    q1.push_back(e);
    pushed++;
  endtask

  // Start pulse sampled at the next edge; result expected at the negedge after edge start+9.
  task automatic start_set(input int i0, input logic [15:0] c0, input int i1, input logic [15:0] c1);
    @(negedge clk);
    start = 1'b1;
    push_exp(i0, c0, i1, c1, cyc + 10);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    chk("result_timeout", {31'd0, (q0.size() != 0 || q1.size() != 0)}, 32'd0);
  endtask

  task automatic check_pulse(input int which, input logic [15:0] mx, input logic [15:0] my,
                             input logic [15:0] c, input logic [3:0] ix, input logic bz);
    exp_t e;
    if (which == 0) begin
      if (q0.size() == 0) begin chk("unexpected_pulse0", 32'd1, 32'd0); return; end
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) begin chk("unexpected_pulse1", 32'd1, 32'd0); return; end
      e = q1.pop_front();
    end
    chk(which == 0 ? "idx0" : "idx1", {28'd0, ix}, {28'd0, e.idx});
    chk(which == 0 ? "cost0" : "cost1", {16'd0, c}, {16'd0, e.cost});
    chk(which == 0 ? "mvx0" : "mvx1", {16'd0, mx}, {16'd0, e.mvx});
    chk(which == 0 ? "mvy0" : "mvy1", {16'd0, my}, {16'd0, e.mvy});
    chk(which == 0 ? "latency0" : "latency1", cyc, e.vcyc);
    chk(which == 0 ? "busy_at_pulse0" : "busy_at_pulse1", {31'd0, bz}, 32'd1);
  endtask

  // Result monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid0 === 1'b1) begin pulses0++; check_pulse(0, mvx0, mvy0, cost0, idx0, busy0); end
    if (valid1 === 1'b1) begin pulses1++; check_pulse(1, mvx1, mvy1, cost1, idx1, busy1); end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mask = 8'h00;
    set_all(16'd0);
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_valid", {31'd0, valid0}, 32'd0);
    chk("reset_outs", {mvx0, mvy0}, 32'd0);
    chk("reset_cost_idx", {12'd0, cost0, idx0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Strictly decreasing costs: last neighbour wins in both instances.
    set_cost(0, 16'd100);
    for (int i = 1; i < 9; i++) set_cost(i, 16'(100 - 10 * i));
    mask = 8'hFF;
    start_set(8, 16'd20, 8, 16'd30);
    chk("busy_during_scan", {31'd0, busy0}, 32'd1);
    wait_done();
    @(negedge clk);
    chk("idle_busy", {31'd0, busy0}, 32'd0);
    chk("hold_idx", {28'd0, idx0}, 32'd8);

    // Reset for two edges mid-scan aborts the set: no pulse, outputs cleared.
    set_all(16'd50);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_outs", {mvx0, mvy0}, 32'd0);
    chk("midreset_cost_idx", {12'd0, cost0, idx0}, 32'd0);
    chk("midreset_b_cost_idx", {12'd0, cost1, idx1}, 32'd0);
    repeat (15) @(negedge clk);
    chk("midreset_still_idle", {30'd0, busy0, busy1}, 32'd0);

    // Ties: all equal -> centre.
    set_all(16'd50);
    start_set(0, 16'd50, 0, 16'd50);
    wait_done();

    // Ties between neighbours -> lower index.
    set_all(16'd70); set_cost(0, 16'd60); set_cost(3, 16'd40); set_cost(6, 16'd40);
    start_set(3, 16'd40, 3, 16'd50);
    wait_done();

    // Masked cheapest neighbour is skipped.
    set_all(16'd200); set_cost(5, 16'd1); mask = 8'hEF;
    start_set(0, 16'd200, 0, 16'd200);
    wait_done();

    // Empty mask -> centre even though every neighbour is cheaper.
    set_cost(0, 16'd100);
    for (int i = 1; i < 9; i++) set_cost(i, 16'(100 - 10 * i));
    mask = 8'h00;
    start_set(0, 16'd100, 0, 16'd100);
    wait_done();

    // Bias makes a slightly cheaper neighbour lose.
    set_all(16'd200); set_cost(0, 16'd100); set_cost(2, 16'd95); mask = 8'hFF;
    start_set(2, 16'd95, 0, 16'd100);
    wait_done();

    // Saturation at the top of the cost range.
    set_all(16'hFFFF); set_cost(2, 16'hFFFA);
    start_set(2, 16'hFFFA, 0, 16'hFFFF);
    wait_done();

    // Handshake: starts during the scan and at the DONE edge are ignored; the
    // start sampled at E10 is accepted. Negative mv_x passes through unchanged.
    set_all(16'd200);
    cand[0] = {16'hFFFD, 16'h0005, 16'd100};
    @(negedge clk);
    start = 1'b1;
    n = cyc + 1;
    push_exp(0, 16'd100, 0, 16'd100, n + 9);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; set_all(16'd0);
    @(negedge clk); start = 1'b0;
    chk("busy_mid_handshake", {31'd0, busy0}, 32'd1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    set_cost(0, 16'd100);
    for (int i = 1; i < 9; i++) set_cost(i, 16'(100 - 10 * i));
    push_exp(8, 16'd20, 8, 16'd30, n + 19);
    @(negedge clk); start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);

    chk("pulse_count0", pulses0, pushed);
    chk("pulse_count1", pulses1, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
